multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, port reset.
REQ-002 clk  input  1  rising-edge clock for the state register.
REQ-003 reset  input  1  async active-low; 0 forces state FETCH immediately.
REQ-004 Op  input  2  instruction[27:26]; 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 Funct  input  6  instruction[25:20]; [5]=I, [4:1]=cmd, [0]=S (L for memory).
REQ-006 Rd  input  4  destination register field.
REQ-007 PCS, RegW, MemW, NoWrite  output  1 each  unconditioned requests to the condition-gating stage.
REQ-008 FlagW  output  2  flag write request; [1]=NZ, [0]=CV.
REQ-009 NextPC, IRWrite, AdrSrc, ALUSrcA  output  1 each  datapath controls.
REQ-010 ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc  output  2 each  datapath controls.
REQ-011 State  output  4  current state encoding, for debug and verification.

Function
REQ-012 The state register SHALL be a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL go to FETCH.
REQ-013 Transitions SHALL be: FETCH->DECODE.
REQ-014 DECODE transitions: Op=01->MEMADR; Op=00 with Funct[5]=0->EXECUTER, with Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH.
REQ-015 MEMADR transitions: Funct[0]=1->MEMREAD, else MEMWRITE.
REQ-016 MEMREAD->MEMWB; EXECUTER and EXECUTEI->ALUWB; MEMWB, MEMWRITE, ALUWB and BRANCH->FETCH.
REQ-017 Control outputs not listed for a state SHALL be 0 (ResultSrc and ALUSrcB = 00).
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWRITE: AdrSrc=1, MemW=1.
- EXECUTER: ALUSrcB=00, ALUOp=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1.
- ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALUOp and Branch SHALL be internal only.
REQ-018 ALU decode when ALUOp=0 SHALL give ALUControl=00 (add), FlagW=00 and NoWrite=0.
REQ-019 ALU decode when ALUOp=1 SHALL be by cmd:
- 0100 ADD->00; 0010 SUB->01; 0000 AND->10; 1100 ORR->11.
- 1010 CMP->01 with NoWrite=1 and FlagW=11.
- Any other cmd->00 with FlagW=00.
REQ-020 For non-CMP commands with ALUOp=1, FlagW[1] SHALL equal Funct[0] and FlagW[0] SHALL equal Funct[0] AND (ALUControl is 00 or 01).
REQ-021 PCS SHALL equal Branch OR (Rd=1111 AND RegW).
REQ-022 ImmSrc SHALL equal Op; RegSrc[0] SHALL be (Op=10); RegSrc[1] SHALL be (Op=01); both are combinational in every state.
REQ-023 Outputs SHALL be combinational from state and instruction fields, with no added latency.
REQ-024 Instruction fields SHALL be sampled only in DECODE and MEMADR; changes elsewhere SHALL NOT affect transitions.

Reset
REQ-025 While reset=0, State SHALL be 0 and outputs SHALL show FETCH values: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, RegW=MemW=PCS=0.
REQ-026 Reset asserted in any state SHALL abort that state asynchronously; the first rising edge after release SHALL move to DECODE.

Verification
REQ-027 Op=00, Funct=001000, Rd=0011: states 0,1,6,8,0; ALUWB shows RegW=1, ALUControl=00, FlagW=00, PCS=0.
REQ-028 Op=01, Funct=011001: states 0,1,2,3,4,0; MEMREAD AdrSrc=1; MEMWB RegW=1, ResultSrc=01.
REQ-029 Op=01, Funct=011000: states 0,1,2,5,0; MEMWRITE MemW=1, AdrSrc=1, RegW=0.
REQ-030 Op=00, Funct=100101 (SUBS imm): EXECUTEI shows ALUSrcB=01, ALUControl=01, FlagW=11.
- Funct=110101 (CMP imm): NoWrite=1, FlagW=11.
REQ-031 Op=10: states 0,1,9,0 with PCS=1 in BRANCH; Op=00, Rd=1111 ADD: PCS=1 in ALUWB only.
REQ-032 Reset pulled low during MEMREAD: State=0 before the next edge, MemW=RegW=0; Op=11 returns DECODE->FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for a multicycle ARM-style datapath. A Moore state register
// steps each instruction through fetch, decode and its execute states. The
// datapath controls are decoded combinationally from the current state and
// the live instruction fields, so they change in the same cycle as the state.
//
// Ports
//   clk        rising-edge clock for the state register
//   reset      asynchronous, active-low; 0 forces FETCH immediately
//   Op         instruction[27:26]: 00 data-proc, 01 memory, 10 branch, 11 undefined
//   Funct      instruction[25:20]: [5]=I, [4:1]=cmd, [0]=S (L for memory)
//   Rd         destination register field
//   PCS, RegW, MemW, NoWrite, FlagW
//              unconditioned write requests to the condition-gating stage
//   NextPC, IRWrite, AdrSrc, ALUSrcA, ResultSrc, ALUSrcB, ALUControl,
//   ImmSrc, RegSrc
//              datapath controls
//   State      current state code (debug / verification)
//
// Handshake: none. The controller free-runs one state per clock; the
// instruction fields must be stable in DECODE and MEMADR, the only states
// whose transitions look at them.
// ---------------------------------------------------------------------------
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   output logic       PCS,
   output logic       RegW,
   output logic       MemW,
   output logic       NoWrite,
   output logic [1:0] FlagW,
   output logic       NextPC,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_e;

   state_e     state_q;
   state_e     state_d;

   logic       branch;
   logic       alu_op;
   logic [3:0] cmd;
   logic       known_cmd;

   assign cmd = Funct[4:1];

   // Next-state logic. Unused codes 10-15 fall into the default and recover
   // to FETCH.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (Op)
               2'b01:   state_d = S_MEMADR;
               2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Moore decode of the per-state datapath controls.
   always_comb begin
      NextPC    = 1'b0;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      RegW      = 1'b0;
      MemW      = 1'b0;
      branch    = 1'b0;
      alu_op    = 1'b0;
      case (state_q)
         S_FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = 1'b1;
            NextPC    = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_MEMADR:  ALUSrcB = 2'b01;
         S_MEMREAD: AdrSrc  = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegW      = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            MemW   = 1'b1;
         end
         S_EXECUTER: alu_op = 1'b1;
         S_EXECUTEI: begin
            ALUSrcB = 2'b01;
            alu_op  = 1'b1;
         end
         S_ALUWB: RegW = 1'b1;
         S_BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            branch    = 1'b1;
         end
         default: ;
      endcase
   end

   // ALU decode. Unrecognised commands add and request no flag update; CMP
   // always updates all flags and suppresses the register write.
   always_comb begin
      ALUControl = 2'b00;
      FlagW      = 2'b00;
      NoWrite    = 1'b0;
      known_cmd  = 1'b0;
      if (alu_op) begin
         case (cmd)
            4'b0100: begin ALUControl = 2'b00; known_cmd = 1'b1; end
            4'b0010: begin ALUControl = 2'b01; known_cmd = 1'b1; end
            4'b0000: begin ALUControl = 2'b10; known_cmd = 1'b1; end
            4'b1100: begin ALUControl = 2'b11; known_cmd = 1'b1; end
            4'b1010: begin
               ALUControl = 2'b01;
               NoWrite    = 1'b1;
               FlagW      = 2'b11;
            end
            default: ;
         endcase
         // C/V only make sense for the arithmetic ops (ALUControl 00/01).
         if (known_cmd) FlagW = {Funct[0], Funct[0] & ~ALUControl[1]};
      end
   end

   // A write to R15 is a branch as far as the PC is concerned.
   assign PCS    = branch | ((Rd == 4'b1111) & RegW);
   assign ImmSrc = Op;
   assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
   assign State  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, RegW, MemW, NoWrite;
  logic [1:0] FlagW;
  logic       NextPC, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .FlagW(FlagW),
    .NextPC(NextPC), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packed view of every control output, same field order as exp_ctrl.
  logic [19:0] obs_ctrl;
  assign obs_ctrl = {PCS, RegW, MemW, NoWrite, FlagW, NextPC, IRWrite, AdrSrc,
                     ALUSrcA, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc};

  // ---------------- reference model ----------------
  // State numbers visited by one instruction, starting at FETCH.
  task automatic build_path(input logic [1:0] op, input logic [5:0] funct,
                            output int path[6], output int len);
    path = '{0, 1, 0, 0, 0, 0};
    len  = 2;
    if (op == 2'b01) begin
      path[2] = 2;
      if (funct[0]) begin path[3] = 3; path[4] = 4; len = 5; end
      else          begin path[3] = 5; len = 4; end
    end else if (op == 2'b00) begin
      path[2] = funct[5] ? 7 : 6;
      path[3] = 8;
      len = 4;
    end else if (op == 2'b10) begin
      path[2] = 9;
      len = 3;
    end
  endtask

  // Expected control outputs for a state number and the currently driven fields.
  function automatic logic [19:0] exp_ctrl(input int st, input logic [1:0] op,
                                           input logic [5:0] funct, input logic [3:0] rd);
    logic regw, memw, br, aluop, npc, irw, adr, srca, nowr, pcs, s;
    logic [1:0] rsrc, bsrc, ctl, flw;
    logic [3:0] c;
    {regw, memw, br, aluop, npc, irw, adr, srca} = '0;
    rsrc = 2'd0; bsrc = 2'd0;
    case (st)
      0: begin srca = 1; bsrc = 2; rsrc = 2; irw = 1; npc = 1; end
      1: begin srca = 1; bsrc = 2; rsrc = 2; end
      2: bsrc = 1;
      3: adr = 1;
      4: begin rsrc = 1; regw = 1; end
      5: begin adr = 1; memw = 1; end
      6: aluop = 1;
      7: begin bsrc = 1; aluop = 1; end
      8: regw = 1;
      9: begin bsrc = 1; rsrc = 2; br = 1; end
      default: ;
    endcase
    c = funct[4:1];
    s = funct[0];
    ctl = 0; flw = 0; nowr = 0;
    if (aluop) begin
      if (c == 4'b1010) begin
        ctl = 1; nowr = 1; flw = 2'b11;
      end else if (c == 4'b0100 || c == 4'b0010 || c == 4'b0000 || c == 4'b1100) begin
        ctl = (c == 4'b0100) ? 2'd0 : (c == 4'b0010) ? 2'd1 : (c == 4'b0000) ? 2'd2 : 2'd3;
        flw = {s, s & (ctl < 2)};
      end
    end
    pcs = br | ((rd == 4'd15) & regw);
    return {pcs, regw, memw, nowr, flw, npc, irw, adr, srca, rsrc, bsrc, ctl,
            op, (op == 2'b01), (op == 2'b10)};
  endfunction

  // ---------------- scoreboard / checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Runs one instruction from FETCH back to FETCH. With scramble set, the
  // fields are randomised in every state that must ignore them.
  task automatic run_instr(input string tag, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] rd,
                           input bit scramble);
    int path[6];
    int len;
    build_path(op, funct, path, len);
    for (int i = 0; i < len; i++) begin
      if (scramble && path[i] != 1 && path[i] != 2) begin
        Op    = 2'($urandom_range(0, 3));
        Funct = 6'($urandom_range(0, 63));
        Rd    = 4'($urandom_range(0, 15));
      end else begin
        Op = op; Funct = funct; Rd = rd;
      end
      #2;
      check({tag, "_state"}, 32'(State), 32'(path[i]));
      check({tag, "_ctrl"}, 32'(obs_ctrl), 32'(exp_ctrl(path[i], Op, Funct, Rd)));
      @(posedge clk);
      #1;
    end
    check({tag, "_end"}, 32'(State), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_state", 32'(State), 32'd0);
    check("rst_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(0, Op, Funct, Rd)));
    @(negedge clk);
    reset = 1'b1;

    run_instr("add_reg",  2'b00, 6'b001000, 4'b0011, 1'b0);
    run_instr("ldr",      2'b01, 6'b011001, 4'b0010, 1'b0);
    run_instr("str",      2'b01, 6'b011000, 4'b0010, 1'b0);
    run_instr("subs_imm", 2'b00, 6'b100101, 4'b0001, 1'b0);
    run_instr("cmp_imm",  2'b00, 6'b110101, 4'b0001, 1'b0);
    run_instr("branch",   2'b10, 6'b000000, 4'b0000, 1'b0);
    run_instr("add_pc",   2'b00, 6'b001000, 4'b1111, 1'b0);
    run_instr("ands",     2'b00, 6'b000001, 4'b0100, 1'b0);
    run_instr("orrs",     2'b00, 6'b011001, 4'b0100, 1'b0);
    run_instr("undef_cmd",2'b00, 6'b011111, 4'b0100, 1'b0);
    run_instr("undef_op", 2'b11, 6'b101010, 4'b1111, 1'b0);

    // Asynchronous reset in the middle of a load.
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd5;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_abort_state", 32'(State), 32'd3);
    #1 reset = 1'b0;
    #1;
    check("abort_state", 32'(State), 32'd0);
    check("abort_ctrl", 32'(obs_ctrl), 32'(exp_ctrl(0, Op, Funct, Rd)));
    @(negedge clk);
    reset = 1'b1;
    run_instr("post_abort_undef", 2'b11, 6'b000000, 4'd0, 1'b0);

    // Random instructions, fields scrambled outside DECODE/MEMADR.
    for (int n = 0; n < 40; n++) begin
      run_instr("rand", 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                4'($urandom_range(0, 15)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
